// File: rtl/serial_link_credit_rx.sv
// Receive-side credit flow control: buffers link flits in a NumCredits-deep FIFO
// and accumulates freed slots as credits to hand back to the peer transmitter.
module serial_link_credit_rx #(
   parameter int DataWidth       = 32,
   parameter int NumCredits      = 8,
   parameter int ForceSendThresh = NumCredits - 1
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [DataWidth-1:0]            flit_i,
   input  logic                            flit_valid_i,
   output logic [DataWidth-1:0]            data_o,
   output logic                            data_valid_o,
   input  logic                            data_ready_i,
   output logic [$clog2(NumCredits):0]     credits_o,
   output logic                            credits_force_o,
   input  logic                            credits_taken_i,
   output logic                            overflow_o,
   output logic [$clog2(NumCredits):0]     fill_o
);

   localparam int CntW = $clog2(NumCredits) + 1;
   localparam int PtrW = (NumCredits > 1) ? $clog2(NumCredits) : 1;
   localparam logic [PtrW-1:0] PtrLast   = PtrW'(NumCredits - 1);
   localparam logic [CntW-1:0] CntMax    = CntW'(NumCredits);
   localparam logic [CntW-1:0] ThreshVal = CntW'(ForceSendThresh);

   // Depth need not be a power of two, so wrap by compare-and-clear.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + PtrW'(1);
   endfunction

   // The peer can never legitimately be owed more than the buffer depth.
   function automatic logic [CntW-1:0] cnt_sat_inc(input logic [CntW-1:0] c,
                                                   input logic          inc);
      return (inc && (c != CntMax)) ? c + CntW'(1) : c;
   endfunction

   logic [DataWidth-1:0] mem [NumCredits];
   logic [PtrW-1:0]      rd_ptr, wr_ptr, rd_next, wr_next;
   logic [CntW-1:0]      fill, fill_next;
   logic [CntW-1:0]      cnt, cnt_next;
   logic                 ovf;
   logic [DataWidth-1:0] head, head_next;
   logic                 full, pop, push, drop;

   assign full = (fill == CntMax);
   assign pop  = (fill != '0) && data_ready_i;
   // A pop at full frees the slot the incoming flit needs in the same cycle.
   assign push = flit_valid_i && (!full || pop);
   assign drop = flit_valid_i && full && !pop;

   assign rd_next = pop  ? ptr_inc(rd_ptr) : rd_ptr;
   assign wr_next = push ? ptr_inc(wr_ptr) : wr_ptr;

   always_comb begin
      fill_next = fill;
      case ({push, pop})
         2'b10:   fill_next = fill + CntW'(1);
         2'b01:   fill_next = fill - CntW'(1);
         default: fill_next = fill;
      endcase
   end

   always_comb begin
      cnt_next = cnt_sat_inc(cnt, pop);
      if (credits_taken_i) begin
         cnt_next = pop ? CntW'(1) : '0;
      end
   end

   // Registered head: bypass the incoming flit when it lands in the slot that
   // becomes the head, otherwise read the already-written entry.
   always_comb begin
      head_next = head;
      if (fill_next != '0) begin
         if (push && (rd_next == wr_ptr)) begin
            head_next = flit_i;
         end else begin
            head_next = mem[rd_next];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= flit_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         head   <= '0;
      end else begin
         rd_ptr <= rd_next;
         wr_ptr <= wr_next;
         fill   <= fill_next;
         cnt    <= cnt_next;
         ovf    <= ovf | drop;
         head   <= head_next;
      end
   end

   assign data_o          = head;
   assign data_valid_o    = (fill != '0);
   assign credits_o       = cnt;
   assign credits_force_o = (cnt >= ThreshVal);
   assign overflow_o      = ovf;
   assign fill_o          = fill;

endmodule

// File: tb/tb_serial_link_credit_rx.sv
// Bench for serial_link_credit_rx: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the receiver.
module tb_serial_link_credit_rx;

   localparam int NC = 8;
   localparam int DW = 32;

   logic          clk;
   logic          rst_i;
   logic [DW-1:0] flit_i;
   logic          flit_valid_i;
   logic [DW-1:0] data_o;
   logic          data_valid_o;
   logic          data_ready_i;
   logic [3:0]    credits_o;
   logic          credits_force_o;
   logic          credits_taken_i;
   logic          overflow_o;
   logic [3:0]    fill_o;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] q[$];
   int            credits;
   bit            ovf;
   logic [DW-1:0] exp_data;

   serial_link_credit_rx #(
      .DataWidth       (DW),
      .NumCredits      (NC),
      .ForceSendThresh (NC - 1)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .flit_i          (flit_i),
      .flit_valid_i    (flit_valid_i),
      .data_o          (data_o),
      .data_valid_o    (data_valid_o),
      .data_ready_i    (data_ready_i),
      .credits_o       (credits_o),
      .credits_force_o (credits_force_o),
      .credits_taken_i (credits_taken_i),
      .overflow_o      (overflow_o),
      .fill_o          (fill_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("fill", 32'(fill_o), 32'(q.size()));
      chk("valid", 32'(data_valid_o), 32'(q.size() > 0));
      chk("data", data_o, exp_data);
      chk("credits", 32'(credits_o), 32'(credits));
      chk("force", 32'(credits_force_o), 32'(credits >= NC - 1));
      chk("overflow", 32'(overflow_o), 32'(ovf));
   endtask

   // One clock: drive inputs, advance the model, then sample after the edge.
   task automatic step(input bit r, input bit v, input logic [DW-1:0] f,
                       input bit rdy, input bit tk);
      bit pop_m;
      bit full_m;
      rst_i           = r;
      flit_valid_i    = v;
      flit_i          = f;
      data_ready_i    = rdy;
      credits_taken_i = tk;
      if (r) begin
         q.delete();
         credits  = 0;
         ovf      = 1'b0;
         exp_data = '0;
      end else begin
         pop_m  = (q.size() > 0) && rdy;
         full_m = (q.size() == NC);
         if (tk) credits = pop_m ? 1 : 0;
         else if (pop_m && credits < NC) credits++;
         if (pop_m) void'(q.pop_front());
         if (v) begin
            if (!full_m || pop_m) q.push_back(f);
            else ovf = 1'b1;
         end
         if (q.size() > 0) exp_data = q[0];
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      rst_i = 1'b1; flit_i = '0; flit_valid_i = 1'b0;
      data_ready_i = 1'b0; credits_taken_i = 1'b0;
      q.delete(); credits = 0; ovf = 1'b0; exp_data = '0;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_data", data_o, 32'h0);
      chk("reset_credits", 32'(credits_o), 32'h0);

      // Basic fill
      for (int i = 0; i < NC; i++) step(0, 1, 32'h10 + i, 0, 0);
      chk("basic_fill", 32'(fill_o), 32'd8);
      chk("basic_head", data_o, 32'h10);
      chk("basic_credits", 32'(credits_o), 32'd0);
      chk("basic_ovf", 32'(overflow_o), 32'd0);

      // Overflow: dropped flit, sticky flag
      step(0, 1, 32'hDEAD, 0, 0);
      chk("ovf_set", 32'(overflow_o), 32'd1);
      chk("ovf_fill", 32'(fill_o), 32'd8);
      step(0, 0, 0, 0, 0);
      chk("ovf_sticky", 32'(overflow_o), 32'd1);

      // Drain 7 without returning credits
      for (int i = 0; i < 7; i++) begin
         chk("drain_data", data_o, 32'h10 + i);
         step(0, 0, 0, 1, 0);
      end
      chk("force_credits", 32'(credits_o), 32'd7);
      chk("force_on", 32'(credits_force_o), 32'd1);
      step(0, 0, 0, 0, 1);
      chk("taken_credits", 32'(credits_o), 32'd0);
      chk("taken_force", 32'(credits_force_o), 32'd0);
      chk("drain_last", data_o, 32'h17);
      step(0, 0, 0, 1, 0);
      chk("drain_empty", 32'(data_valid_o), 32'd0);

      // Simultaneous take and pop at credits=3
      for (int i = 0; i < 3; i++) step(0, 1, 32'h30 + i, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("pre_take_credits", 32'(credits_o), 32'd3);
      step(0, 0, 0, 1, 1);
      chk("take_pop_credits", 32'(credits_o), 32'd1);

      // Full-with-pop push, after a reset to clear the sticky flag
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < NC; i++) step(0, 1, 32'h20 + i, 0, 0);
      step(0, 1, 32'h99, 1, 0);
      chk("fullpop_fill", 32'(fill_o), 32'd8);
      chk("fullpop_ovf", 32'(overflow_o), 32'd0);
      for (int i = 0; i < NC; i++) begin
         chk("fullpop_drain", data_o, (i == NC - 1) ? 32'h99 : 32'h21 + i);
         step(0, 0, 0, 1, 0);
      end
      chk("credit_saturate", 32'(credits_o), 32'd8);

      // Reset mid-run with fill 4, credits 2
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 1, 32'h50 + i, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("mid_fill", 32'(fill_o), 32'd4);
      chk("mid_credits", 32'(credits_o), 32'd2);
      step(1, 1, 32'h77, 1, 0);
      chk("rst_fill", 32'(fill_o), 32'd0);
      chk("rst_valid", 32'(data_valid_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      step(0, 1, 32'h42, 0, 0);
      chk("post_rst_fill", 32'(fill_o), 32'd1);
      chk("post_rst_data", data_o, 32'h42);
      step(0, 0, 0, 1, 0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(99) == 0), 1'($urandom_range(1)), $urandom,
              ($urandom_range(3) != 0), ($urandom_range(7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
